// File: rtl/calendar_pkg.sv
// Calendar constants and helpers shared by the date stage.
// Field encodings, month names and month-length arithmetic.
package calendar_pkg;

  typedef enum logic [1:0] {
    FLD_DAY   = 2'd0,
    FLD_MONTH = 2'd1,
    FLD_YEAR  = 2'd2
  } field_t;

  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] DEC = 4'd12;

  function automatic logic is_leap(
    input logic [15:0] y
  );
    return (y % 16'd4 == 16'd0) &&
           ((y % 16'd100 != 16'd0) ||
            (y % 16'd400 == 16'd0));
  endfunction

  function automatic logic [4:0] days_in_month(
    input logic [3:0] m,
    input logic       leap
  );
    logic [4:0] d;
    d = 5'd31;
    unique case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      FEB:     d = leap ? 5'd29 : 5'd28;
      default: d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/month_length.sv
// Combinational days-in-month lookup for a given month and year.
// Gregorian leap rule applied to the full year value.
module month_length
  import calendar_pkg::*;
#(
  parameter int YEAR_BITS = 12
) (
  input  logic [3:0]           month,
  input  logic [YEAR_BITS-1:0] year,
  output logic [4:0]           dim
);

  logic [15:0] y16;

  assign y16 = 16'(year);
  assign dim = days_in_month(month, is_leap(y16));

endmodule

// File: rtl/date_counter.sv
// Day/month/year stage fed by the hour counter's day carry.
// Set mode edits one field at a time with clamp on month/year.
module date_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_MIN  = 2000,
  parameter int YEAR_MAX  = 2099,
  parameter int YEAR_BITS = $clog2(YEAR_MAX+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 set,
  input  logic                 sel_next,
  input  logic                 inc,
  output logic [4:0]           day,
  output logic [3:0]           month,
  output logic [YEAR_BITS-1:0] year,
  output logic [1:0]           field,
  output logic                 year_carry
);

  localparam logic [YEAR_BITS-1:0] YMIN =
    YEAR_BITS'(YEAR_MIN);
  localparam logic [YEAR_BITS-1:0] YMAX =
    YEAR_BITS'(YEAR_MAX);

  logic [4:0]           day_q, day_d;
  logic [3:0]           month_q, month_d;
  logic [YEAR_BITS-1:0] year_q, year_d;
  field_t               fld_q, fld_d;
  logic                 carry_q, carry_d;

  logic [3:0]           month_nx, cl_month;
  logic [YEAR_BITS-1:0] year_nx, cl_year;
  logic [4:0]           dim_cur, dim_clamp;

  assign month_nx = (month_q == DEC) ?
                    4'd1 : month_q + 4'd1;
  assign year_nx  = (year_q == YMAX) ?
                    YMIN : year_q + YEAR_BITS'(1);

  // Month/year as they will be after a set-mode inc
  assign cl_month = (fld_q == FLD_MONTH) ?
                    month_nx : month_q;
  assign cl_year  = (fld_q == FLD_YEAR) ?
                    year_nx : year_q;

  month_length #(.YEAR_BITS(YEAR_BITS)) u_cur (
    .month (month_q),
    .year  (year_q),
    .dim   (dim_cur)
  );

  month_length #(.YEAR_BITS(YEAR_BITS)) u_clamp (
    .month (cl_month),
    .year  (cl_year),
    .dim   (dim_clamp)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= YMIN;
      fld_q   <= FLD_DAY;
      carry_q <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      fld_q   <= fld_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    fld_d   = fld_q;
    carry_d = 1'b0;
    if (set) begin
      if (inc) begin
        unique case (1'b1)
          (fld_q == FLD_DAY):
            day_d = (day_q >= dim_cur) ?
                    5'd1 : day_q + 5'd1;
          (fld_q == FLD_MONTH): month_d = month_nx;
          (fld_q == FLD_YEAR):  year_d  = year_nx;
          default: ;
        endcase
        if (fld_q != FLD_DAY && day_q > dim_clamp)
          day_d = dim_clamp;
      end
      if (sel_next) begin
        unique case (fld_q)
          FLD_DAY:   fld_d = FLD_MONTH;
          FLD_MONTH: fld_d = FLD_YEAR;
          default:   fld_d = FLD_DAY;
        endcase
      end
    end else if (tick) begin
      if (day_q < dim_cur) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d   = 5'd1;
        month_d = month_nx;
        if (month_q == DEC) begin
          year_d  = year_nx;
          carry_d = (year_q == YMAX);
        end
      end
    end
  end

  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign field      = fld_q;
  assign year_carry = carry_q;

endmodule

// File: tb/tb_date_counter.sv
// Scoreboard bench for date_counter: default range and a
// YEAR_MAX=2399 copy share stimulus, each with its own model.
module tb_date_counter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic set = 1'b0;
  logic sel_next = 1'b0;
  logic inc = 1'b0;

  logic [4:0]  day_a, day_b;
  logic [3:0]  month_a, month_b;
  logic [11:0] year_a, year_b;
  logic [1:0]  field_a, field_b;
  logic        yc_a, yc_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  date_counter u_a (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .set        (set),
    .sel_next   (sel_next),
    .inc        (inc),
    .day        (day_a),
    .month      (month_a),
    .year       (year_a),
    .field      (field_a),
    .year_carry (yc_a)
  );

  date_counter #(.YEAR_MAX(2399)) u_b (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .set        (set),
    .sel_next   (sel_next),
    .inc        (inc),
    .day        (day_b),
    .month      (month_b),
    .year       (year_b),
    .field      (field_b),
    .year_carry (yc_b)
  );

  typedef struct {
    int d; int m; int y; int f; int c;
  } dt_t;

  dt_t mdl [2];
  int  ymax [2] = '{2099, 2399};
  dt_t q [$];

  function automatic int dim(int m, int y);
    bit leap;
    leap = (y % 4 == 0) &&
           ((y % 100 != 0) || (y % 400 == 0));
    case (m)
      4, 6, 9, 11: return 30;
      2:           return leap ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  function automatic void mdl_reset();
    for (int u = 0; u < 2; u++)
      mdl[u] = '{1, 1, 2000, 0, 0};
  endfunction

  function automatic void mdl_step(
    int u, bit tk, bit st, bit sn, bit ic
  );
    dt_t s;
    s = mdl[u];
    s.c = 0;
    if (st) begin
      if (ic) begin
        if (s.f == 0) begin
          s.d = (s.d == dim(s.m, s.y)) ? 1 : s.d + 1;
        end else begin
          if (s.f == 1)
            s.m = (s.m == 12) ? 1 : s.m + 1;
          else
            s.y = (s.y == ymax[u]) ? 2000 : s.y + 1;
          if (s.d > dim(s.m, s.y))
            s.d = dim(s.m, s.y);
        end
      end
      if (sn) s.f = (s.f == 2) ? 0 : s.f + 1;
    end else if (tk) begin
      if (s.d < dim(s.m, s.y)) begin
        s.d = s.d + 1;
      end else begin
        s.d = 1;
        if (s.m == 12) begin
          s.m = 1;
          if (s.y == ymax[u]) begin
            s.y = 2000;
            s.c = 1;
          end else begin
            s.y = s.y + 1;
          end
        end else begin
          s.m = s.m + 1;
        end
      end
    end
    mdl[u] = s;
  endfunction

  function automatic dt_t dut_out(int u);
    dt_t r;
    if (u == 0) begin
      r.d = int'(day_a);   r.m = int'(month_a);
      r.y = int'(year_a);  r.f = int'(field_a);
      r.c = int'(yc_a);
    end else begin
      r.d = int'(day_b);   r.m = int'(month_b);
      r.y = int'(year_b);  r.f = int'(field_b);
      r.c = int'(yc_b);
    end
    return r;
  endfunction

  task automatic chk(
    input string tag, input int got, input int exp
  );
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_unit(
    input string p, input dt_t g, input dt_t e
  );
    chk({p, ".day"},   g.d, e.d);
    chk({p, ".month"}, g.m, e.m);
    chk({p, ".year"},  g.y, e.y);
    chk({p, ".field"}, g.f, e.f);
    chk({p, ".carry"}, g.c, e.c);
  endtask

  task automatic step(
    input bit tk, input bit st,
    input bit sn, input bit ic
  );
    tick = tk; set = st; sel_next = sn; inc = ic;
    @(posedge clock);
    for (int u = 0; u < 2; u++) begin
      mdl_step(u, tk, st, sn, ic);
      q.push_back(mdl[u]);
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      dt_t e;
      e = q.pop_front();
      cmp_unit(u == 0 ? "A" : "B", dut_out(u), e);
    end
  endtask

  task automatic expect_date(
    input string tag, input int u,
    input int d, input int m, input int y
  );
    dt_t g;
    g = dut_out(u);
    chk({tag, ".d"}, g.d, d);
    chk({tag, ".m"}, g.m, m);
    chk({tag, ".y"}, g.y, y);
  endtask

  // Leaves set mode on, field=DAY
  task automatic set_date(
    input int u, input int d, input int m, input int y
  );
    for (int k = 0; k < 4 && mdl[u].f != 2; k++)
      step(0, 1, 1, 0);
    for (int k = 0; k < 400 && mdl[u].y != y; k++)
      step(0, 1, 0, 1);
    for (int k = 0; k < 4 && mdl[u].f != 1; k++)
      step(0, 1, 1, 0);
    for (int k = 0; k < 12 && mdl[u].m != m; k++)
      step(0, 1, 0, 1);
    for (int k = 0; k < 4 && mdl[u].f != 0; k++)
      step(0, 1, 1, 0);
    for (int k = 0; k < 31 && mdl[u].d != d; k++)
      step(0, 1, 0, 1);
    expect_date("setdate", u, d, m, y);
  endtask

  initial begin
    mdl_reset();
    #12;
    expect_date("rst", 0, 1, 1, 2000);
    chk("rst.field", int'(field_a), 0);
    chk("rst.carry", int'(yc_a), 0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0, 0);

    set_date(0, 31, 1, 2023);
    step(1, 0, 0, 0);
    expect_date("jan31", 0, 1, 2, 2023);
    set_date(0, 28, 2, 2023);
    step(1, 0, 0, 0);
    expect_date("feb28", 0, 1, 3, 2023);
    set_date(0, 28, 2, 2024);
    step(1, 0, 0, 0);
    expect_date("leap28", 0, 29, 2, 2024);
    step(1, 0, 0, 0);
    expect_date("leap29", 0, 1, 3, 2024);

    set_date(1, 28, 2, 2100);
    step(1, 0, 0, 0);
    expect_date("c2100", 1, 1, 3, 2100);
    set_date(1, 28, 2, 2000);
    step(1, 0, 0, 0);
    expect_date("c2000", 1, 29, 2, 2000);

    set_date(0, 31, 12, 2099);
    step(1, 0, 0, 0);
    expect_date("wrap", 0, 1, 1, 2000);
    chk("wrap.carry1", int'(yc_a), 1);
    step(0, 0, 0, 0);
    chk("wrap.carry0", int'(yc_a), 0);
    set_date(0, 31, 12, 2099);
    step(1, 1, 0, 0);
    expect_date("setwins", 0, 31, 12, 2099);
    chk("setwins.carry", int'(yc_a), 0);

    set_date(0, 31, 3, 2023);
    step(0, 1, 1, 0);
    chk("sel.field", int'(field_a), 1);
    step(0, 1, 0, 1);
    expect_date("mclamp", 0, 30, 4, 2023);
    set_date(0, 29, 2, 2024);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("ysel.field", int'(field_a), 2);
    step(0, 1, 0, 1);
    expect_date("yclamp", 0, 28, 2, 2025);

    set_date(0, 31, 1, 2023);
    step(0, 1, 0, 1);
    expect_date("dwrap", 0, 1, 1, 2023);
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    chk("both.month", int'(month_a), 2);
    chk("both.field", int'(field_a), 2);

    step(0, 1, 0, 1);
    #2;
    reset = 1'b0;
    #2;
    expect_date("arst", 0, 1, 1, 2000);
    chk("arst.field", int'(field_a), 0);
    chk("arst.carry", int'(yc_a), 0);
    mdl_reset();
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_date("post", 0, 2, 1, 2000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Calendar date stage directly downstream of the hour-of-day counter. Consumes that counter's one-clock day carry and advances day/month/year with correct month lengths and Gregorian leap years.
- Provides set mode: a field-select FSM plus an increment input let the user edit day, month or year.
- Outputs feed the display/formatting stage.

Parameters:
- YEAR_MIN, 2000, lowest representable year; reset value and wrap target.
- YEAR_MAX, 2099, highest representable year; wrap point.
- YEAR_BITS, $clog2(YEAR_MAX+1), width of the year output.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  day carry from upstream hour counter; each clock it is high counts one day.
- set  input  1  level; 1 = set mode, 0 = run mode.
- sel_next  input  1  one-clock pulse; advance the selected field (set mode only).
- inc  input  1  one-clock pulse; increment the selected field (set mode only).
- day  output  5  day of month, 1..31.
- month  output  4  month, 1..12.
- year  output  YEAR_BITS  year, YEAR_MIN..YEAR_MAX.
- field  output  2  selected field: 0=DAY, 1=MONTH, 2=YEAR.
- year_carry  output  1  one-clock pulse on the YEAR_MAX to YEAR_MIN rollover.

Behaviour:
- Reset (async, reset=0): day=1, month=1, year=YEAR_MIN, field=DAY, year_carry=0. Reset mid-edit aborts the edit and restores these values.
- All outputs are registered. Each update appears one clock after the sampling edge.
- Days in month:
  - Months 4, 6, 9, 11 have 30 days.
  - Month 2 has 29 days if leap, else 28.
  - All other months have 31 days.
  - leap = (year%4==0) && ((year%100!=0) || (year%400==0)).
- Run mode (set=0, tick=1):
  - If day < dim: day+1.
  - Else: day=1 and month+1.
  - If month was 12: month=1 and year+1.
  - If year was YEAR_MAX: year=YEAR_MIN and year_carry=1 for exactly one clock.
- year_carry is 0 on every other cycle.
- sel_next and inc are ignored in run mode. field holds its value.
- Set mode (set=1):
  - tick is ignored. No date advance occurs and year_carry is never asserted, even on a wrap.
  - Field FSM: sel_next moves DAY -> MONTH -> YEAR -> DAY.
  - inc on DAY: day+1, wrapping dim -> 1. No carry into month.
  - inc on MONTH: month+1, wrapping 12 -> 1. No carry into year.
  - inc on YEAR: year+1, wrapping YEAR_MAX -> YEAR_MIN.
  - Clamp: after a MONTH or YEAR inc, if day exceeds dim for the new month/year, day is set to that dim on the same edge.
- Simultaneous events:
  - inc and sel_next on the same edge: inc applies to the current field, and field advances on that same edge.
  - set=1 with tick=1: set wins.
- Leaving set mode keeps the edited date and field. Run counting resumes on the next tick.
- Input levels: a tick, inc or sel_next held high counts once per clock. Inputs are assumed synchronous and already debounced upstream.
- Arithmetic: no out-of-range values are ever produced. day=0 and month=0 are unreachable.

Decomposition:
- calendar_pkg holds:
  - field encodings FLD_DAY/FLD_MONTH/FLD_YEAR;
  - month constants FEB, DEC;
  - function is_leap(year);
  - function days_in_month(month, leap).
- One combinational sub-module, month_length (inputs month, year; output dim). It is instantiated twice: once for the current date and once for the post-increment month/year used by the clamp.

Test Plan:
- Reset then release -> day=1, month=1, year=2000, field=0, year_carry=0. Assert reset while set=1 with field=YEAR -> same reset values immediately.
- Set 2023-01-31 then pulse tick -> 2023-02-01. Set 2023-02-28 then tick -> 2023-03-01. Set 2024-02-28 then tick -> 2024-02-29; second tick -> 2024-03-01.
- With YEAR_MAX=2399, check century years: 2100-02-28 + tick -> 2100-03-01; 2000-02-28 + tick -> 2000-02-29.
- Set 2099-12-31 (default params) then tick -> 2000-01-01, with year_carry=1 for one clock then 0. Same date with set=1 and tick=1 -> date unchanged, year_carry=0.
- Set mode on 2023-03-31: sel_next -> field=1, then inc -> 2023-04-30 (clamped). Set year=2024 and month=2, day=29: select YEAR, inc -> 2025-02-28.
- set=1, field=DAY, day=31 in Jan: inc -> day=1, month stays 1. inc and sel_next together on field=MONTH -> month+1 and field=YEAR.
